nav_ctrl: RTL and testbench
===========================

Name: nav_ctrl

Overview:
- Motion-execution stage directly downstream of the maze-solve FSM.
- Consumes strt_hdng / strt_mv commands plus the wall-sensor openings.
- Runs a heading-settle phase, or a forward move with speed ramp-up and ramp-down.
- Returns a single-cycle mv_cmplt to the solver and drives the forward-speed command and enables for the PID/motor stage.

Parameters:
FAST_SIM, 1, 1 selects a large ramp step for simulation (FRWRD_INC = 11'h018); 0 selects FRWRD_INC = 11'h002.
MAX_SPD, 11'h2A0, forward-speed ceiling (saturation value).
MIN_FRWRD, 11'h0D0, speed loaded at the start of a forward move.

Ports:
clk  input  1  system clock; all state changes on posedge clk.
rst  input  1  synchronous, active-high reset.
strt_hdng  input  1  one-cycle pulse from solver: settle on new heading.
strt_mv  input  1  one-cycle pulse from solver: move forward one segment.
stp_lft  input  1  stop at first new left opening (left-wall follower).
stp_rght  input  1  stop at first new right opening.
hdng_rdy  input  1  one-cycle strobe, new heading sample valid; paces the ramp.
at_hdng  input  1  PID reports heading error within tolerance.
lft_opn  input  1  left wall open.
rght_opn  input  1  right wall open.
frwrd_opn  input  1  path ahead clear; 0 = wall imminent.
mv_cmplt  output  1  registered one-cycle pulse: heading settled or move finished.
moving  output  1  high in any state except IDLE.
en_fusion  output  1  moving && frwrd_spd > MAX_SPD>>1.
frwrd_spd  output  11  forward speed command, unsigned.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, frwrd_spd=0, mv_cmplt=0, emer=0, lft_prev=0, rght_prev=0. Consequently moving=0 and en_fusion=0.
- Reset mid-move aborts the move immediately; no mv_cmplt is produced.
- lft_prev / rght_prev register lft_opn / rght_opn every cycle in all states.
  - lft_rise = lft_opn & ~lft_prev; rght_rise likewise.
  - An opening already present when strt_mv arrives therefore never counts as new.
- States: IDLE, HDNG, RAMP_UP, RAMP_DWN.
- IDLE:
  - frwrd_spd holds 0.
  - strt_hdng -> HDNG.
  - else strt_mv -> RAMP_UP, frwrd_spd <= MIN_FRWRD, emer <= 0.
  - If both pulse in the same cycle, strt_hdng wins.
- In any non-IDLE state, strt_hdng and strt_mv are ignored.
- HDNG:
  - frwrd_spd = 0.
  - When at_hdng = 1: -> IDLE, mv_cmplt <= 1 for the next cycle only. Minimum latency is 1 cycle after entry.
- RAMP_UP:
  - On hdng_rdy: frwrd_spd <= min(frwrd_spd + FRWRD_INC, MAX_SPD). Add is performed 12-bit, then clamped; no wrap.
  - Exit checks, evaluated every cycle in priority order:
    1. ~frwrd_opn -> RAMP_DWN, emer <= 1.
    2. (stp_lft & lft_rise) | (stp_rght & rght_rise) -> RAMP_DWN, emer <= 0.
  - An exit check and hdng_rdy in the same cycle: transition taken, no increment.
- RAMP_DWN:
  - On hdng_rdy: frwrd_spd <= frwrd_spd - dec, saturating at 0.
    - dec = 4*FRWRD_INC if emer, else 2*FRWRD_INC.
  - ~frwrd_opn at any time sets emer <= 1 and keeps it set.
  - When registered frwrd_spd == 0: -> IDLE, mv_cmplt <= 1 for one cycle.
- mv_cmplt:
  - Never high for 2 consecutive cycles.
  - Asserted in the cycle state first reads IDLE.
  - Default 0.
- en_fusion is combinational from registered state/frwrd_spd.

Test Plan:
- Reset behaviour: rst high 2 cycles with strt_mv=1 -> frwrd_spd=0, mv_cmplt=0, moving=0, state IDLE after release.
- Heading settle: strt_hdng pulse, at_hdng raised 5 cycles later -> moving=1 for 6 cycles. Then mv_cmplt high exactly 1 cycle, frwrd_spd=0 throughout.
- Ramp to saturation (FAST_SIM=1): strt_mv, frwrd_opn=1, 25 hdng_rdy strobes.
  - frwrd_spd steps 0x0D0, 0x0E8, ... and reaches 0x2A0 on the 20th strobe, then holds 0x2A0.
  - en_fusion rises once frwrd_spd > 0x150.
- Left-opening stop: at 0x2A0, stp_lft=1, lft_opn 0->1.
  - RAMP_DWN with dec 0x30.
  - 14 hdng_rdy strobes reach 0, then a single mv_cmplt pulse.
  - rght_opn rising during the ramp is ignored.
- Pre-existing opening + emergency: lft_opn=1 before strt_mv, stp_lft=1.
  - The move does not stop on lft_opn.
  - At 0x2A0, drop frwrd_opn -> dec 0x60, 0 after 7 strobes, mv_cmplt.
- Simultaneous and ignored commands:
  - strt_hdng and strt_mv in the same cycle -> HDNG entered.
  - strt_mv during RAMP_UP -> no effect on frwrd_spd.
  - rst asserted mid-RAMP_DWN -> IDLE next edge, no mv_cmplt.

Source files
------------

// File: rtl/nav_ctrl.sv
// Motion-execution stage: heading settle, or forward move with speed ramp
// up/down, handing mv_cmplt back to the maze solver.
module nav_ctrl #(
   parameter bit          FAST_SIM  = 1'b1,
   parameter logic [10:0] MAX_SPD   = 11'h2A0,
   parameter logic [10:0] MIN_FRWRD = 11'h0D0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_hdng,
   input  logic        strt_mv,
   input  logic        stp_lft,
   input  logic        stp_rght,
   input  logic        hdng_rdy,
   input  logic        at_hdng,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        frwrd_opn,
   output logic        mv_cmplt,
   output logic        moving,
   output logic        en_fusion,
   output logic [10:0] frwrd_spd
);

   localparam logic [10:0] FRWRD_INC = FAST_SIM ? 11'h018 : 11'h002;
   localparam logic [10:0] DEC_NORM  = FRWRD_INC << 1;
   localparam logic [10:0] DEC_EMER  = FRWRD_INC << 2;
   localparam logic [10:0] FUS_THR   = MAX_SPD >> 1;

   typedef enum logic [1:0] {
      IDLE,
      HDNG,
      RAMP_UP,
      RAMP_DWN
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] frwrd_spd_q, frwrd_spd_d;
   logic        mv_cmplt_q, mv_cmplt_d;
   logic        emer_q, emer_d;
   logic        lft_prev_q, rght_prev_q;

   logic        lft_rise, rght_rise;
   logic        stop_hit;
   logic [11:0] spd_sum;
   logic [10:0] spd_dec;

   assign lft_rise  = lft_opn & ~lft_prev_q;
   assign rght_rise = rght_opn & ~rght_prev_q;
   assign stop_hit  = (stp_lft & lft_rise) | (stp_rght & rght_rise);
   assign spd_sum   = {1'b0, frwrd_spd_q} + {1'b0, FRWRD_INC};
   assign spd_dec   = emer_q ? DEC_EMER : DEC_NORM;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         frwrd_spd_q <= '0;
         mv_cmplt_q  <= 1'b0;
         emer_q      <= 1'b0;
         lft_prev_q  <= 1'b0;
         rght_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frwrd_spd_q <= frwrd_spd_d;
         mv_cmplt_q  <= mv_cmplt_d;
         emer_q      <= emer_d;
         lft_prev_q  <= lft_opn;
         rght_prev_q <= rght_opn;
      end
   end

   always_comb begin
      state_d     = state_q;
      frwrd_spd_d = frwrd_spd_q;
      mv_cmplt_d  = 1'b0;
      emer_d      = emer_q;
      unique case (state_q)
         IDLE: begin
            frwrd_spd_d = '0;
            if (strt_hdng) begin
               state_d = HDNG;
            end else if (strt_mv) begin
               state_d     = RAMP_UP;
               frwrd_spd_d = MIN_FRWRD;
               emer_d      = 1'b0;
            end
         end
         HDNG: begin
            frwrd_spd_d = '0;
            if (at_hdng) begin
               state_d    = IDLE;
               mv_cmplt_d = 1'b1;
            end
         end
         RAMP_UP: begin
            // exits take priority over the speed step in the same cycle
            if (!frwrd_opn) begin
               state_d = RAMP_DWN;
               emer_d  = 1'b1;
            end else if (stop_hit) begin
               state_d = RAMP_DWN;
               emer_d  = 1'b0;
            end else if (hdng_rdy) begin
               if (spd_sum > {1'b0, MAX_SPD}) begin
                  frwrd_spd_d = MAX_SPD;
               end else begin
                  frwrd_spd_d = spd_sum[10:0];
               end
            end
         end
         RAMP_DWN: begin
            if (!frwrd_opn) begin
               emer_d = 1'b1;
            end
            if (frwrd_spd_q == '0) begin
               state_d    = IDLE;
               mv_cmplt_d = 1'b1;
            end else if (hdng_rdy) begin
               if (frwrd_spd_q > spd_dec) begin
                  frwrd_spd_d = frwrd_spd_q - spd_dec;
               end else begin
                  frwrd_spd_d = '0;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            frwrd_spd_d = '0;
         end
      endcase
   end

   assign mv_cmplt  = mv_cmplt_q;
   assign moving    = (state_q != IDLE);
   assign en_fusion = moving && (frwrd_spd_q > FUS_THR);
   assign frwrd_spd = frwrd_spd_q;

endmodule

// File: tb/tb_nav_ctrl.sv
// Scoreboard bench for nav_ctrl: expectations queued as stimulus is driven,
// popped and compared one cycle later after the clock edge.
module tb_nav_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        strt_hdng, strt_mv, stp_lft, stp_rght;
   logic        hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn;
   logic        mv_cmplt, moving, en_fusion;
   logic [10:0] frwrd_spd;

   typedef struct packed {
      logic [10:0] spd;
      logic        mv;
      logic        mov;
      logic        fus;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   m_spd = 0;

   nav_ctrl #(
      .FAST_SIM (1'b1),
      .MAX_SPD  (11'h2A0),
      .MIN_FRWRD(11'h0D0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .strt_hdng(strt_hdng),
      .strt_mv  (strt_mv),
      .stp_lft  (stp_lft),
      .stp_rght (stp_rght),
      .hdng_rdy (hdng_rdy),
      .at_hdng  (at_hdng),
      .lft_opn  (lft_opn),
      .rght_opn (rght_opn),
      .frwrd_opn(frwrd_opn),
      .mv_cmplt (mv_cmplt),
      .moving   (moving),
      .en_fusion(en_fusion),
      .frwrd_spd(frwrd_spd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input int spd, input bit mv, input bit mov);
      exp_t e;
      e.spd = spd[10:0];
      e.mv  = mv;
      e.mov = mov;
      e.fus = mov && (spd > 'h150);
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("frwrd_spd", frwrd_spd, e.spd);
         chk("mv_cmplt", mv_cmplt, e.mv);
         chk("moving", moving, e.mov);
         chk("en_fusion", en_fusion, e.fus);
      end
      strt_hdng = 1'b0;
      strt_mv   = 1'b0;
      hdng_rdy  = 1'b0;
   endtask

   task automatic strobe_up();
      hdng_rdy = 1'b1;
      m_spd = (m_spd + 'h18 > 'h2A0) ? 'h2A0 : m_spd + 'h18;
      push(m_spd, 1'b0, 1'b1);
      tick();
      push(m_spd, 1'b0, 1'b1);
      tick();
   endtask

   task automatic strobe_dn(input int dec);
      hdng_rdy = 1'b1;
      m_spd = (m_spd > dec) ? m_spd - dec : 0;
      push(m_spd, 1'b0, 1'b1);
      tick();
      if (m_spd != 0) begin
         push(m_spd, 1'b0, 1'b1);
         tick();
      end
   endtask

   task automatic finish_move();
      push(0, 1'b1, 1'b0);
      tick();
      push(0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic start_move();
      strt_mv = 1'b1;
      m_spd = 'h0D0;
      push(m_spd, 1'b0, 1'b1);
      tick();
   endtask

   initial begin
      rst = 1'b1; strt_hdng = 1'b0; strt_mv = 1'b1;
      stp_lft = 1'b0; stp_rght = 1'b0; hdng_rdy = 1'b0;
      at_hdng = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
      frwrd_opn = 1'b1;

      // reset held two cycles with strt_mv asserted
      tick();
      strt_mv = 1'b1;
      push(0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      push(0, 1'b0, 1'b0);
      tick();

      // heading settle: moving for 6 cycles then one mv_cmplt
      strt_hdng = 1'b1;
      push(0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         push(0, 1'b0, 1'b1);
         tick();
      end
      at_hdng = 1'b1;
      push(0, 1'b1, 1'b0);
      tick();
      at_hdng = 1'b0;
      push(0, 1'b0, 1'b0);
      tick();

      // ramp to saturation, strt_mv mid-ramp ignored
      start_move();
      for (int i = 0; i < 25; i++) begin
         if (i == 3) strt_mv = 1'b1;
         strobe_up();
         if (i == 18) chk("pre_sat", m_spd, 'h298);
         if (i == 19) chk("sat_20", frwrd_spd, 'h2A0);
      end

      // new left opening stops the move, normal decel
      stp_lft = 1'b1;
      lft_opn = 1'b1;
      push(m_spd, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 14; i++) begin
         rght_opn = (i % 2 == 0);
         strobe_dn('h30);
      end
      finish_move();
      lft_opn = 1'b0; rght_opn = 1'b0;
      push(0, 1'b0, 1'b0);
      tick();

      // pre-existing opening ignored, then emergency stop
      lft_opn = 1'b1;
      push(0, 1'b0, 1'b0);
      tick();
      start_move();
      for (int i = 0; i < 20; i++) strobe_up();
      frwrd_opn = 1'b0;
      push(m_spd, 1'b0, 1'b1);
      tick();
      frwrd_opn = 1'b1;
      for (int i = 0; i < 7; i++) strobe_dn('h60);
      finish_move();
      lft_opn = 1'b0; stp_lft = 1'b0;

      // simultaneous commands: heading wins
      strt_hdng = 1'b1; strt_mv = 1'b1;
      push(0, 1'b0, 1'b1);
      tick();
      at_hdng = 1'b1;
      push(0, 1'b1, 1'b0);
      tick();
      at_hdng = 1'b0;
      push(0, 1'b0, 1'b0);
      tick();

      // reset mid ramp-down: no mv_cmplt
      start_move();
      for (int i = 0; i < 3; i++) strobe_up();
      stp_rght = 1'b1; rght_opn = 1'b1;
      push(m_spd, 1'b0, 1'b1);
      tick();
      strobe_dn('h30);
      rst = 1'b1;
      push(0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      push(0, 1'b0, 1'b0);
      tick();
      push(0, 1'b0, 1'b0);
      tick();

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
